// File: rtl/tlc_sequencer.sv
// tlc_sequencer: four-way intersection signal sequencer.
//
// NS rests on green; EW green is granted only on demand from the EW vehicle
// sensor or a latched pedestrian request. Every duration is counted in ticks of
// the timebase enable pulse, never in clk cycles. All outputs are registered
// and change on the same clk edge as the state.
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous reset, active-low
//   tick_i         one-clk-wide timebase enable (nominally 1 Hz)
//   ew_sensor_i    EW vehicle present (level)
//   ped_req_i      pedestrian button (level or pulse)
//   flash_mode_i   flashing-yellow override (only with TLC_FLASH_EN)
//   ns_light_o     NS head {red, yellow, green}
//   ew_light_o     EW head {red, yellow, green}
//   ped_walk_o     walk lamp
//   ped_pending_o  pedestrian request latched, not yet served
//   remaining_o    ticks left in the current state, minus 1
//
// Optional feature macro: TLC_FLASH_EN (adds flash_mode_i and flash logic).

module tlc_sequencer #(
    parameter int unsigned GREEN_NS = 10,
    parameter int unsigned GREEN_EW = 6,
    parameter int unsigned YELLOW   = 3,
    parameter int unsigned ALLRED   = 1,
    parameter int unsigned WALK     = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic       ew_sensor_i,
    input  logic       ped_req_i,
`ifdef TLC_FLASH_EN
    input  logic       flash_mode_i,
`endif
    output logic [2:0] ns_light_o,
    output logic [2:0] ew_light_o,
    output logic       ped_walk_o,
    output logic       ped_pending_o,
    output logic [7:0] remaining_o
);

    typedef enum logic [2:0] {
        StNsG,
        StNsY,
        StArA,
        StEwG,
        StEwY,
        StArB
    } state_e;

    localparam logic [7:0] LdGreenNs = 8'(GREEN_NS - 1);
    localparam logic [7:0] LdGreenEw = 8'(GREEN_EW - 1);
    localparam logic [7:0] LdYellow  = 8'(YELLOW - 1);
    localparam logic [7:0] LdAllRed  = 8'(ALLRED - 1);
    // Timer value at which the walk lamp goes dark (only reachable if WALK < GREEN_EW).
    localparam logic [7:0] WalkEnd   = 8'(GREEN_EW - 1 - WALK);
    localparam logic       WalkShort = (WALK < GREEN_EW);

    localparam logic [2:0] Red    = 3'b100;
    localparam logic [2:0] Yellow = 3'b010;
    localparam logic [2:0] Green  = 3'b001;

    state_e     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       pend_q, pend_d;
    logic       walk_q, walk_d;
    logic [2:0] ns_q, ns_d;
    logic [2:0] ew_q, ew_d;

`ifdef TLC_FLASH_EN
    logic flash_q, flash_d;
    logic phase_q, phase_d;
`endif

    // Lamp decode for a state, returned as {ns, ew}.
    function automatic logic [5:0] lamps(state_e s);
        unique case (s)
            StNsG:   lamps = {Green, Red};
            StNsY:   lamps = {Yellow, Red};
            StEwG:   lamps = {Red, Green};
            StEwY:   lamps = {Red, Yellow};
            default: lamps = {Red, Red};
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pend_d  = pend_q | ped_req_i;
        walk_d  = walk_q;
`ifdef TLC_FLASH_EN
        flash_d = flash_mode_i;
        phase_d = phase_q;
`endif

        if (tick_i) begin
            if (timer_q != 8'd0) begin
                timer_d = timer_q - 8'd1;
                if (state_q == StEwG && WalkShort && timer_d == WalkEnd) begin
                    walk_d = 1'b0;
                end
            end else begin
                unique case (state_q)
                    StNsG: begin
                        if (ew_sensor_i || pend_q) begin
                            state_d = StNsY;
                            timer_d = LdYellow;
                        end else begin
                            timer_d = LdGreenNs;  // rest on main road
                        end
                    end
                    StNsY: begin
                        state_d = StArA;
                        timer_d = LdAllRed;
                    end
                    StArA: begin
                        state_d = StEwG;
                        timer_d = LdGreenEw;
                        pend_d  = 1'b0;  // a request on this very edge is served too
                        walk_d  = (WALK != 0);
                    end
                    StEwG: begin
                        state_d = StEwY;
                        timer_d = LdYellow;
                        walk_d  = 1'b0;
                    end
                    StEwY: begin
                        state_d = StArB;
                        timer_d = LdAllRed;
                    end
                    default: begin
                        state_d = StNsG;
                        timer_d = LdGreenNs;
                    end
                endcase
            end
        end

        {ns_d, ew_d} = lamps(state_d);

`ifdef TLC_FLASH_EN
        if (flash_mode_i) begin
            // Sequencer frozen; only the pedestrian latch keeps working.
            state_d = state_q;
            timer_d = timer_q;
            walk_d  = 1'b0;
            pend_d  = pend_q | ped_req_i;
            phase_d = phase_q ^ tick_i;
            ns_d    = phase_d ? 3'b000 : Yellow;
            ew_d    = phase_d ? 3'b000 : Red;
        end else if (flash_q) begin
            // Leaving flash: restart from the all-red clearance.
            state_d = StArB;
            timer_d = LdAllRed;
            walk_d  = 1'b0;
            pend_d  = pend_q | ped_req_i;
            phase_d = 1'b0;
            {ns_d, ew_d} = lamps(StArB);
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StArB;
            timer_q <= LdAllRed;
            pend_q  <= 1'b0;
            walk_q  <= 1'b0;
            ns_q    <= Red;
            ew_q    <= Red;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            walk_q  <= walk_d;
            ns_q    <= ns_d;
            ew_q    <= ew_d;
        end
    end

`ifdef TLC_FLASH_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flash_q <= 1'b0;
            phase_q <= 1'b0;
        end else begin
            flash_q <= flash_d;
            phase_q <= phase_d;
        end
    end
`endif

    assign ns_light_o    = ns_q;
    assign ew_light_o    = ew_q;
    assign ped_walk_o    = walk_q;
    assign ped_pending_o = pend_q;
    assign remaining_o   = timer_q;

endmodule

// File: tb/tb_tlc_sequencer.sv
// Testbench for tlc_sequencer: table-driven vectors, hand-written corner
// sequences and randomized stimulus against a phase/elapsed-tick model.

module tb_tlc_sequencer;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       ew_sensor;
    logic       ped_req;
    logic       flash_mode;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       ped_walk;
    logic       ped_pending;
    logic [7:0] remaining;

    int checks = 0;
    int errors = 0;

    tlc_sequencer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .tick_i       (tick),
        .ew_sensor_i  (ew_sensor),
        .ped_req_i    (ped_req),
`ifdef TLC_FLASH_EN
        .flash_mode_i (flash_mode),
`endif
        .ns_light_o   (ns_light),
        .ew_light_o   (ew_light),
        .ped_walk_o   (ped_walk),
        .ped_pending_o(ped_pending),
        .remaining_o  (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase index in cycle order and ticks elapsed in it.
    // 0 NS_G, 1 NS_Y, 2 AR_A, 3 EW_G, 4 EW_Y, 5 AR_B
    int         dur[6]    = '{10, 3, 1, 6, 3, 1};
    logic [2:0] ns_tab[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] ew_tab[6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};
    localparam int WalkTicks = 4;

    int m_phase;
    int m_elapsed;
    bit m_pend;

    function automatic void model_reset();
        m_phase   = 5;
        m_elapsed = 0;
        m_pend    = 1'b0;
    endfunction

    function automatic void model_step(bit t, bit s, bit r);
        bit pend_next;
        pend_next = m_pend | r;
        if (t) begin
            m_elapsed++;
            if (m_elapsed == dur[m_phase]) begin
                m_elapsed = 0;
                if (!(m_phase == 0 && !(s || m_pend))) begin
                    m_phase = (m_phase + 1) % 6;
                    if (m_phase == 3) pend_next = 1'b0;
                end
            end
        end
        m_pend = pend_next;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("ns_light", 32'(ns_light), 32'(ns_tab[m_phase]));
        chk("ew_light", 32'(ew_light), 32'(ew_tab[m_phase]));
        chk("ped_walk", 32'(ped_walk), 32'(m_phase == 3 && m_elapsed < WalkTicks));
        chk("ped_pending", 32'(ped_pending), 32'(m_pend));
        chk("remaining", 32'(remaining), 32'(dur[m_phase] - 1 - m_elapsed));
        chk("never_two_greens", 32'(ns_light[0] & ew_light[0]), 32'd0);
    endtask

    // One clk: drive inputs, step the model on the edge, compare #1 after it.
    task automatic cycle(bit t, bit s, bit r);
        tick      = t;
        ew_sensor = s;
        ped_req   = r;
        @(posedge clk);
        model_step(t, s, r);
        #1;
        chk_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         t;
        bit         s;
        bit         r;
        logic [2:0] ns;
        logic [2:0] ew;
        bit         walk;
        bit         pend;
        logic [7:0] rem;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int walk_on;
        int walk_off;
        bit reached;

        tick       = 1'b0;
        ew_sensor  = 1'b0;
        ped_req    = 1'b0;
        flash_mode = 1'b0;
        rst_n      = 1'b0;
        model_reset();
        #12;
        chk("reset_ns", 32'(ns_light), 32'h4);
        chk("reset_ew", 32'(ew_light), 32'h4);
        chk("reset_walk", 32'(ped_walk), 32'd0);
        chk("reset_pend", 32'(ped_pending), 32'd0);
        chk("reset_rem", 32'(remaining), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table vectors from reset (AR_B, remaining 0).
        vecs[0] = '{1, 0, 0, 3'b001, 3'b100, 0, 0, 8'd9};
        vecs[1] = '{0, 0, 1, 3'b001, 3'b100, 0, 1, 8'd9};
        vecs[2] = '{1, 0, 0, 3'b001, 3'b100, 0, 1, 8'd8};
        vecs[3] = '{0, 0, 0, 3'b001, 3'b100, 0, 1, 8'd8};
        vecs[4] = '{1, 0, 0, 3'b001, 3'b100, 0, 1, 8'd7};
        vecs[5] = '{1, 1, 0, 3'b001, 3'b100, 0, 1, 8'd6};
        vecs[6] = '{0, 1, 0, 3'b001, 3'b100, 0, 1, 8'd6};
        vecs[7] = '{1, 1, 1, 3'b001, 3'b100, 0, 1, 8'd5};
        for (int i = 0; i < 8; i++) begin
            tick      = vecs[i].t;
            ew_sensor = vecs[i].s;
            ped_req   = vecs[i].r;
            @(posedge clk);
            model_step(vecs[i].t, vecs[i].s, vecs[i].r);
            #1;
            chk("vec_ns", 32'(ns_light), 32'(vecs[i].ns));
            chk("vec_ew", 32'(ew_light), 32'(vecs[i].ew));
            chk("vec_walk", 32'(ped_walk), 32'(vecs[i].walk));
            chk("vec_pend", 32'(ped_pending), 32'(vecs[i].pend));
            chk("vec_rem", 32'(remaining), 32'(vecs[i].rem));
        end

        // Rest on main: 50 ticks with no demand stays in NS_G.
        do_reset();
        cycle(1, 0, 0);
        for (int k = 1; k <= 50; k++) begin
            cycle(1, 0, 0);
            chk("rest_ns_green", 32'(ns_light), 32'h1);
            chk("rest_remaining", 32'(remaining), 32'(9 - (k % 10)));
        end

        // Pedestrian: single pulse, count walk ticks inside EW_G.
        do_reset();
        cycle(1, 0, 0);
        cycle(0, 0, 1);
        walk_on  = 0;
        walk_off = 0;
        for (int k = 0; k < 40; k++) begin
            cycle(1, 0, 0);
            if (ew_light == 3'b001) begin
                if (ped_walk) walk_on++;
                else walk_off++;
            end
        end
        chk("ped_walk_ticks", 32'(walk_on), 32'd4);
        chk("ped_dark_ticks", 32'(walk_off), 32'd2);

        // Request on the EW_G entry edge is served immediately.
        do_reset();
        reached = 1'b0;
        for (int k = 0; k < 100 && !reached; k++) begin
            if (m_phase == 2) begin
                cycle(1, 1, 1);
                reached = 1'b1;
            end else begin
                cycle(1, 1, 0);
            end
        end
        chk("reach_ar_a", 32'(reached), 32'd1);
        chk("entry_req_served", 32'(ped_pending), 32'd0);
        cycle(1, 0, 1);
        chk("req_in_ewg_latched", 32'(ped_pending), 32'd1);

        // Async reset mid-EW_G, then release with tick held high.
        reached = 1'b0;
        for (int k = 0; k < 100 && !reached; k++) begin
            cycle(1, 1, 0);
            if (m_phase == 3 && m_elapsed == 2) reached = 1'b1;
        end
        chk("reach_ew_g", 32'(reached), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midreset_ns", 32'(ns_light), 32'h4);
        chk("midreset_ew", 32'(ew_light), 32'h4);
        chk("midreset_walk", 32'(ped_walk), 32'd0);
        chk("midreset_rem", 32'(remaining), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, 0, 0);
        chk("post_reset_ns_green", 32'(ns_light), 32'h1);

        // Tick gating: one tick every 5 clks with demand present.
        do_reset();
        for (int k = 0; k < 400; k++) cycle((k % 5) == 4, 1'b1, (k % 97) == 3);

        // Randomized stimulus with varying tick density.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            bit t;
            if (k < 2000) t = ($urandom_range(0, 3) == 0);
            else t = ($urandom_range(0, 9) != 0);
            cycle(t, ($urandom_range(0, 9) < 2), ($urandom_range(0, 39) == 0));
        end

`ifdef TLC_FLASH_EN
        // Flash: lamps toggle per tick, timer frozen, exit to AR_B.
        do_reset();
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        begin
            logic [7:0] frozen;
            frozen = remaining;
            tick = 1'b0;
            flash_mode = 1'b1;
            @(posedge clk);
            #1;
            chk("flash_ns_even", 32'(ns_light), 32'h2);
            chk("flash_ew_even", 32'(ew_light), 32'h4);
            for (int k = 1; k <= 6; k++) begin
                tick = 1'b1;
                @(posedge clk);
                #1;
                chk("flash_ns", 32'(ns_light), (k % 2) ? 32'h0 : 32'h2);
                chk("flash_ew", 32'(ew_light), (k % 2) ? 32'h0 : 32'h4);
                chk("flash_walk", 32'(ped_walk), 32'd0);
                chk("flash_frozen", 32'(remaining), 32'(frozen));
            end
            tick = 1'b0;
            flash_mode = 1'b0;
            @(posedge clk);
            #1;
            chk("flash_exit_ns", 32'(ns_light), 32'h4);
            chk("flash_exit_ew", 32'(ew_light), 32'h4);
            chk("flash_exit_rem", 32'(remaining), 32'd0);
            model_reset();
            cycle(1, 0, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case something stalls the main sequence.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/tlc_sequencer.md
Name: tlc_sequencer

Overview:
- Four-way intersection controller that sequences the north-south (NS) and east-west (EW) signal heads and the pedestrian walk lamp.
- Timed by the 1-second enable pulse from the timebase block. All durations are counted in ticks, never in clk cycles.
- Sits between the timebase (clock-enable generator) and the lamp drivers.
- NS is the default main road. EW green is granted only on demand, from a vehicle sensor or a pedestrian request.

Parameters:
- GREEN_NS, 10, minimum NS green duration in ticks (1-255)
- GREEN_EW, 6, EW green duration in ticks (1-255)
- YELLOW, 3, yellow duration in ticks, both directions (1-255)
- ALLRED, 1, all-red clearance in ticks (1-255)
- WALK, 4, ped_walk duration in ticks at the start of EW green; must be <= GREEN_EW

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- tick  in  1  one-clk-wide enable pulse from timebase, nominally 1 Hz
- ew_sensor  in  1  EW vehicle present, level, sampled on clk
- ped_req  in  1  pedestrian button, level or pulse, sampled on clk
- ns_light  out  3  {red, yellow, green}, exactly one bit high
- ew_light  out  3  {red, yellow, green}, exactly one bit high
- ped_walk  out  1  walk lamp
- ped_pending  out  1  latched pedestrian request not yet served
- remaining  out  8  ticks left in the current state, minus 1

Behaviour:
- States: NS_G, NS_Y, AR_A, EW_G, EW_Y, AR_B.
- Cycle order: AR_B -> NS_G -> NS_Y -> AR_A -> EW_G -> EW_Y -> AR_B.
- Outputs are registered and driven from state; all update on the same clk edge as the state change.
- Lamp values per state:
  - NS_G: ns = 001, ew = 100
  - NS_Y: ns = 010, ew = 100
  - AR_A, AR_B: ns = 100, ew = 100
  - EW_G: ns = 100, ew = 001
  - EW_Y: ns = 100, ew = 010
- Reset (rst = 0, asynchronous):
  - state = AR_B, timer = ALLRED-1
  - ns_light = ew_light = 100
  - ped_walk = 0, ped_pending = 0
- Timer:
  - On entering a state, timer is loaded with that state's duration minus 1.
  - On each tick with timer > 0, timer decrements.
  - On a tick with timer == 0, the state expires.
  - No change occurs without a tick.
  - remaining mirrors timer.
- Transition latency: the state changes on the same clk edge that samples the expiring tick, so each state lasts exactly N ticks.
- NS_G expiry:
  - If ew_sensor = 1 or ped_pending = 1, go to NS_Y.
  - Otherwise stay in NS_G and reload GREEN_NS-1 (rest-on-main extension).
- All other expiries advance unconditionally.
- Pedestrian request:
  - Any clk with ped_req = 1 sets ped_pending.
  - ped_pending clears on the edge entering EW_G; ped_walk goes to 1 on that same edge.
  - ped_walk is 1 for the first WALK ticks of EW_G: clear it when timer == GREEN_EW-1-WALK after a decrement.
  - If WALK == GREEN_EW, ped_walk stays 1 until EW_G exits.
  - If ped_req = 1 on the entry edge itself, the request is served: ped_pending = 0.
  - A request arriving during EW_G after entry sets ped_pending for the next cycle.
- ped_walk is forced to 0 in every state other than EW_G.
- EW_G is a fixed GREEN_EW ticks long; the sensor does not extend it.
- Safety invariant: ns_light[0] and ew_light[0] are never 1 together. No direction goes green directly from the other direction's green or yellow.

Optional Feature:
- Macro: TLC_FLASH_EN.
- When defined:
  - Adds input port flash_mode (1 bit).
  - While flash_mode = 1: ns_light = 010 and ew_light = 100 on even-numbered ticks, and both = 000 on odd ticks (tick-toggled phase flop). ped_walk = 0, timer frozen, ped_pending still latches.
  - On flash_mode falling, the sequencer enters AR_B with timer = ALLRED-1 and the phase flop cleared.
- When undefined: no port, no flash logic; behaviour exactly as above.

Test Plan:
- Reset: rst = 0 mid-EW_G -> immediately ns = ew = 100, ped_walk = 0, remaining = 0. Release with tick held 1 -> NS_G after 1 tick, ns = 001.
- Rest on main: tick every cycle, ew_sensor = 0, ped_req = 0 for 50 ticks -> stays NS_G throughout, remaining cycles 9..0 then 9 again.
- Sensor: ew_sensor = 1 at NS_G entry -> NS_G lasts 10 ticks, then NS_Y for 3, AR_A for 1, EW_G for 6, EW_Y for 3, AR_B for 1, then NS_G.
- Pedestrian: 1-clk ped_req pulse in NS_G, ew_sensor = 0 -> ped_pending = 1 until the EW_G entry edge. ped_walk = 1 for exactly 4 ticks, then 0 for the remaining 2 ticks of EW_G.
- Tick gating: tick pulsed every 5 clks -> state durations are 5x tick counts, with no change on non-tick cycles. Invariant holds: never both greens.
- TLC_FLASH_EN: flash_mode = 1 for 6 ticks -> ns toggles 010/000, ew toggles 100/000, timer frozen. Flash_mode drops -> AR_B with remaining = 0.
